alu_result_sel: RTL and testbench

- Parametrised, registered successor to the MiniCPU ALU result multiplexer.
- Selects one of NUM_SRC functional-unit results (add, shifts, and, or, compare, ...) by opcode select and registers it into a single-stage valid/ready output.
- Out-of-range selects are detected, flagged and counted.
- Sits between the ALU functional units and the register-file write-back stage.

---
 rtl/alu_result_sel.sv | 126 ++++++++++++
 tb/tb_alu_result_sel.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sel.sv
// Registered ALU result selector with a valid/ready output stage and illegal-select tracking.
// Define ALU_RESULT_FLAGS_EN to register zero/negative flags of the selected result.
module alu_result_sel #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sel_err,
    output logic                     err_sticky,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         err_count,
    output logic                     out_zero,
    output logic                     out_neg
);

    // One extra bit so NUM_SRC == 2^SEL_W makes every index legal.
    localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);

    logic             accept;
    logic             sel_bad;
    logic [WIDTH-1:0] sel_val;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             serr_q, serr_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign sel_bad  = ({1'b0, in_sel} >= NSRC);

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_val = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        serr_d  = serr_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_val;
            serr_d  = sel_bad;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // An illegal accept in the same cycle as a clear wins over the clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (accept && sel_bad) begin
            sticky_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            serr_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            serr_q   <= serr_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_sel_err = serr_q;
    assign err_sticky  = sticky_q;
    assign err_count   = cnt_q;

`ifdef ALU_RESULT_FLAGS_EN
    logic zero_q;
    logic neg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (accept) begin
            zero_q <= (sel_val == '0);
            neg_q  <= sel_val[WIDTH-1];
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_sel.sv
// Scoreboard bench for alu_result_sel: directed plan plus randomized traffic
// against a behavioural model of selection, handshake and error counting.
module tb_alu_result_sel;

    localparam int W = 8;
    localparam int N = 6;
    localparam int S = 3;
    localparam int C = 8;
    localparam int CMAX = (1 << C) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [S-1:0]   in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_sel_err;
    logic           err_sticky;
    logic           err_clr;
    logic [C-1:0]   err_count;
    logic           out_zero;
    logic           out_neg;

    alu_result_sel #(
        .WIDTH(W), .NUM_SRC(N), .SEL_W(S), .CNT_W(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_sel(in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel_err(out_sel_err),
        .err_sticky(err_sticky),
        .err_clr(err_clr),
        .err_count(err_count),
        .out_zero(out_zero),
        .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
        logic         z;
        logic         n;
    } exp_t;

    exp_t     sb[$];
    int       total = 0;
    int       bad = 0;
    logic [W-1:0] src[N];
    logic     mv;
    int       mcnt;
    logic     mstk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(int sel);
        exp_t r;
        r.e = (sel >= N);
        r.d = r.e ? '0 : src[sel];
`ifdef ALU_RESULT_FLAGS_EN
        r.z = (r.d == 0);
        r.n = r.d[W-1];
`else
        r.z = 1'b0;
        r.n = 1'b0;
`endif
        return r;
    endfunction

    task automatic cyc(bit v, int sel, bit ordy, bit clr);
        bit acc;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = src[k];
        in_valid  = v;
        in_sel    = sel[S-1:0];
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
        chk("in_ready", in_ready, !mv || ordy);
        chk("out_valid", out_valid, mv);
        chk("err_sticky", err_sticky, mstk);
        chk("err_count", err_count, mcnt);
        acc = v && (!mv || ordy);
        if (acc) sb.push_back(model(sel));
        if (acc) mv = 1'b1;
        else if (mv && ordy) mv = 1'b0;
        if (clr) begin
            mstk = 1'b0;
            mcnt = 0;
        end
        if (acc && sel >= N) begin
            mstk = 1'b1;
            mcnt = clr ? 1 : ((mcnt < CMAX) ? mcnt + 1 : CMAX);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mv   = 1'b0;
        mcnt = 0;
        mstk = 1'b0;
    endtask

    // Monitor: every presented result must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got data %0h expected none", out_data);
            end else begin
                exp_t e;
                e = sb[0];
                chk("out_data", out_data, e.d);
                chk("out_sel_err", out_sel_err, e.e);
                chk("out_zero", out_zero, e.z);
                chk("out_neg", out_neg, e.n);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        in_data = '0;
        in_sel  = '0;
        src = '{8'h12, 8'h24, 8'h09, 8'h10, 8'h3F, 8'h01};
        do_reset(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel_err", out_sel_err, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_neg", out_neg, 0);
        chk("rst_in_ready", in_ready, 0 == 0 ? 1 : 0);

        for (int s = 0; s < N; s++) cyc(1, s, 1, 0);
        cyc(0, 0, 1, 0);

        cyc(1, 4, 1, 0);
        repeat (5) begin
            for (int k = 0; k < N; k++) src[k] = W'($urandom);
            cyc(1, $urandom_range(0, 7), 0, 0);
        end
        src = '{8'h12, 8'h24, 8'h09, 8'h10, 8'h3F, 8'h01};
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);

        cyc(1, 6, 1, 0);
        cyc(1, 7, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);

        repeat (CMAX + 5) cyc(1, 6 + int'($urandom_range(0, 1)), 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 7, 1, 1);
        cyc(0, 0, 1, 0);

        src[1] = 8'h80;
        cyc(1, 1, 1, 0);
        src[3] = 8'h00;
        cyc(1, 3, 1, 0);
        cyc(0, 0, 1, 0);

        cyc(1, 6, 1, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 3, 0, 0);
        do_reset(1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);

        repeat (400) begin
            for (int k = 0; k < N; k++) src[k] = W'($urandom);
            if ($urandom_range(0, 7) == 0) src[$urandom_range(0, N-1)] = '0;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        repeat (3) cyc(0, 0, 1, 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
